// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle between the PC-select mux / imem side and the decode stage.
// stall/flush are level controls sampled each rising edge; there is no valid/ready pair here.
interface pc_fetch_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] pc_next;
  logic [31:0]      instr_f;
  logic [WIDTH-1:0] pc_f;
  logic [WIDTH-1:0] pc_plus4_f;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_plus4_d;
  logic [31:0]      instr_d;
  logic             valid_d;
  logic             halted;

  modport master (
    output stall, flush, pc_next, instr_f,
    input  pc_f, pc_plus4_f, pc_d, pc_plus4_d, instr_d, valid_d, halted
  );

  modport slave (
    input  stall, flush, pc_next, instr_f,
    output pc_f, pc_plus4_f, pc_d, pc_plus4_d, instr_d, valid_d, halted
  );
endinterface

// File: rtl/pc_fetch_reg.sv
// Program counter plus IF/ID pipeline register with stall, flush, post-reset bubble
// and a sticky halt on a misaligned redirect.
module pc_fetch_reg #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]      NOP      = 32'h00000013
) (
  input  logic       clk,
  input  logic       reset,
  pc_fetch_if.slave  bus,
  output logic [1:0] o_dbg_state
);
  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_FIRST = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_pc_f;
  logic [WIDTH-1:0] r_pc_d;
  logic [WIDTH-1:0] r_pc_plus4_d;
  logic [31:0]      r_instr_d;
  logic             r_valid_d;
  logic             r_halted;

  logic [WIDTH-1:0] w_pc_plus4_f;
  logic             w_active;
  logic             w_misalign;
  logic             w_load_pc;
  logic             w_capture;
  logic             w_bubble;

  assign w_pc_plus4_f = r_pc_f + WIDTH'(4);
  assign w_active     = (r_state == S_FIRST) || (r_state == S_RUN);
  // Alignment only matters when pc_next would actually be loaded.
  assign w_misalign   = w_active && !bus.stall && (bus.pc_next[1:0] != 2'b00);
  assign w_load_pc    = w_active && !bus.stall && !w_misalign;
  assign w_capture    = w_load_pc && !bus.flush;
  assign w_bubble     = (r_state == S_RESET) || w_misalign || (w_active && bus.flush);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_RESET;
      r_pc_f       <= RESET_PC;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_instr_d    <= NOP;
      r_valid_d    <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      if (w_load_pc) begin
        r_pc_f <= bus.pc_next;
      end
      if (w_capture) begin
        r_pc_d       <= r_pc_f;
        r_pc_plus4_d <= w_pc_plus4_f;
        r_instr_d    <= bus.instr_f;
        r_valid_d    <= 1'b1;
      end else if (w_bubble) begin
        r_pc_d       <= '0;
        r_pc_plus4_d <= '0;
        r_instr_d    <= NOP;
        r_valid_d    <= 1'b0;
      end
      if (w_misalign) begin
        r_halted <= 1'b1;
      end
      case (r_state)
        S_RESET: r_state <= S_FIRST;
        S_FIRST: r_state <= w_misalign ? S_HALT : S_RUN;
        S_RUN:   r_state <= w_misalign ? S_HALT : S_RUN;
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign bus.pc_f       = r_pc_f;
  assign bus.pc_plus4_f = w_pc_plus4_f;
  assign bus.pc_d       = r_pc_d;
  assign bus.pc_plus4_d = r_pc_plus4_d;
  assign bus.instr_d    = r_instr_d;
  assign bus.valid_d    = r_valid_d;
  assign bus.halted     = r_halted;
  assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_pc_fetch_reg.sv
// Self-checking bench for pc_fetch_reg: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pc_fetch_reg;
  localparam logic [31:0] NOP = 32'h00000013;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  pc_fetch_if #(.WIDTH(32)) bus ();

  pc_fetch_reg #(.WIDTH(32), .RESET_PC(32'h00000000), .NOP(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: what the fetch registers must hold after each edge
  logic [31:0] m_pc, m_pc_d, m_p4_d, m_instr;
  logic        m_valid, m_halted, m_known, m_fresh;

  initial m_known = 1'b0;

  task automatic model_bubble();
    m_pc_d  = 32'h0;
    m_p4_d  = 32'h0;
    m_instr = NOP;
    m_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_pc     = 32'h0;
      model_bubble();
      m_halted = 1'b0;
      m_fresh  = 1'b1;
      m_known  = 1'b1;
    end else if (m_known && !m_halted) begin
      if (m_fresh) begin
        m_fresh = 1'b0;
      end else if (!bus.stall && (bus.pc_next % 4 != 0)) begin
        m_halted = 1'b1;
        model_bubble();
      end else if (bus.stall) begin
        if (bus.flush) model_bubble();
      end else begin
        if (bus.flush) begin
          model_bubble();
        end else begin
          m_pc_d  = m_pc;
          m_p4_d  = m_pc + 32'd4;
          m_instr = bus.instr_f;
          m_valid = 1'b1;
        end
        m_pc = bus.pc_next;
      end
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (m_known) begin
      chk("pc_f",       bus.pc_f,       m_pc);
      chk("pc_plus4_f", bus.pc_plus4_f, m_pc + 32'd4);
      chk("pc_d",       bus.pc_d,       m_pc_d);
      chk("pc_plus4_d", bus.pc_plus4_d, m_p4_d);
      chk("instr_d",    bus.instr_d,    m_instr);
      chk("valid_d",    {31'b0, bus.valid_d}, {31'b0, m_valid});
      chk("halted",     {31'b0, bus.halted},  {31'b0, m_halted});
    end
  end

  // driver
  task automatic step(input logic rst, input logic st, input logic fl,
                      input logic [31:0] pcn, input logic [31:0] ins);
    reset       = rst;
    bus.stall   = st;
    bus.flush   = fl;
    bus.pc_next = pcn;
    bus.instr_f = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    logic [31:0] pcn;
    int r;
    reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.pc_next = 32'h0; bus.instr_f = 32'h0;

    // reset for two cycles
    step(1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    lit("rst_pc_f", bus.pc_f, 32'h0);
    lit("rst_instr_d", bus.instr_d, 32'h00000013);
    lit("rst_valid_d", {31'b0, bus.valid_d}, 32'h0);
    lit("rst_halted", {31'b0, bus.halted}, 32'h0);

    // post-reset bubble then sequential fetch: pc_f 0,0,4,8
    step(0, 0, 0, 32'h4, 32'h11111111);
    lit("first_pc_f", bus.pc_f, 32'h0);
    lit("first_valid_d", {31'b0, bus.valid_d}, 32'h0);
    step(0, 0, 0, 32'h4, 32'h11111111);
    lit("seq_pc_f_4", bus.pc_f, 32'h4);
    lit("seq_pc_d_0", bus.pc_d, 32'h0);
    lit("seq_valid_d", {31'b0, bus.valid_d}, 32'h1);
    lit("seq_instr_d", bus.instr_d, 32'h11111111);
    step(0, 0, 0, 32'h8, 32'h33333333);
    lit("seq_pc_f_8", bus.pc_f, 32'h8);

    // redirect to 0x100
    step(0, 0, 0, 32'h100, 32'hA5A5A5A5);
    lit("redir_pc_f", bus.pc_f, 32'h100);
    lit("redir_instr_d", bus.instr_d, 32'hA5A5A5A5);
    lit("redir_pc_plus4_d", bus.pc_plus4_d, 32'hC);

    // stall three cycles at pc_f=0x10
    step(0, 0, 0, 32'h10, 32'h22222222);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 32'h20, $urandom);
      lit("stall_pc_f", bus.pc_f, 32'h10);
      lit("stall_pc_d", bus.pc_d, 32'h100);
      lit("stall_instr_d", bus.instr_d, 32'h22222222);
    end

    // stall and flush together
    step(0, 1, 1, 32'h20, 32'h44444444);
    lit("sf_pc_f", bus.pc_f, 32'h10);
    lit("sf_instr_d", bus.instr_d, 32'h00000013);
    lit("sf_valid_d", {31'b0, bus.valid_d}, 32'h0);

    // wrap of pc_plus4
    step(0, 0, 0, 32'hFFFFFFFC, 32'h55555555);
    lit("wrap_pc_plus4_f", bus.pc_plus4_f, 32'h0);
    step(0, 0, 0, 32'h0, 32'h66666666);
    lit("wrap_pc_plus4_d", bus.pc_plus4_d, 32'h0);
    lit("wrap_pc_d", bus.pc_d, 32'hFFFFFFFC);

    // reset asserted mid-stall
    step(0, 1, 0, 32'h40, 32'h77777777);
    step(1, 1, 0, 32'h40, 32'h77777777);
    lit("midrst_pc_f", bus.pc_f, 32'h0);
    lit("midrst_pc_d", bus.pc_d, 32'h0);
    lit("midrst_valid_d", {31'b0, bus.valid_d}, 32'h0);
    step(0, 0, 0, 32'h4, 32'h88888888);
    step(0, 0, 0, 32'h4, 32'h88888888);
    lit("restart_pc_f", bus.pc_f, 32'h4);

    // misaligned redirect halts until reset
    step(0, 0, 0, 32'h102, 32'h99999999);
    lit("halt_halted", {31'b0, bus.halted}, 32'h1);
    lit("halt_pc_f", bus.pc_f, 32'h4);
    lit("halt_valid_d", {31'b0, bus.valid_d}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h200, $urandom);
      lit("halt_frozen_pc_f", bus.pc_f, 32'h4);
    end
    step(1, 0, 0, 32'h0, 32'h0);
    lit("halt_rst_pc_f", bus.pc_f, 32'h0);
    lit("halt_rst_halted", {31'b0, bus.halted}, 32'h0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       pcn = {$urandom_range(0, 32'h3FFFFFFF), 2'b00} | 32'($urandom_range(1, 3));
      else if (r < 20) pcn = $urandom & 32'hFFFFFFFC;
      else             pcn = m_pc + 32'd4;
      step(($urandom_range(0, 99) < (m_halted ? 10 : 2)) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
           pcn, $urandom);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
